// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V core and its debug trace streamer.
// Holds the core datapath width, the control-FSM state type exported on state_dbg,
// and the trace frame constants plus the trace serializer state type.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   // Core control-FSM states; FETCH is the encoding the trace block keys on.
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, ALUWB, EXECUTEI, JAL, BEQ, BADSTATE
   } state_t;

   localparam logic [7:0]  TRACE_SYNC        = 8'hA5;
   localparam int unsigned TRACE_FRAME_BYTES = 9;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/trace_uart_if.sv
// Bundle between the core debug outputs and the trace streamer.
//   master: core side (drives en/state/pc/instr, observes UART and status)
//   slave : trace_uart (observes core, drives tx/busy/overflow/drop_cnt)
interface trace_uart_if;
   import riscv_pkg::*;

   logic             en_i;
   state_t           state_i;
   logic [XLEN-1:0]  pc_i;
   logic [XLEN-1:0]  instr_i;
   logic             tx_o;
   logic             busy_o;
   logic             overflow_o;
   logic [7:0]       drop_cnt_o;

   modport master (
      output en_i, state_i, pc_i, instr_i,
      input  tx_o, busy_o, overflow_o, drop_cnt_o
   );

   modport slave (
      input  en_i, state_i, pc_i, instr_i,
      output tx_o, busy_o, overflow_o, drop_cnt_o
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read data (rdata_o shows the head entry).
//   push_i/wdata_i : write; accepted when not full, or when a pop happens the same cycle
//   pop_i/rdata_o  : read; ignored while empty
//   full_o/empty_o/count_o : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CntW'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   // When full, the slot being read this cycle is the one written, so both can proceed.
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) count_d = count_q + CntW'(1);
      if (do_pop && !do_push) count_d = count_q - CntW'(1);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/trace_uart.sv
// Instruction trace streamer. On each entry of the core FSM into FETCH (while enabled) a
// {pc, instr} record is queued; each record is sent as a 9-byte UART 8N1 frame:
// sync byte 0xA5, then pc and instr MSB byte first, each byte LSB bit first.
//   clk_i/rstn_i : clock, asynchronous active-low reset
//   trc          : en/state/pc/instr from the core; tx/busy/overflow/drop_cnt outputs
module trace_uart
   import riscv_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input logic         clk_i,
   input logic         rstn_i,
   trace_uart_if.slave trc
);
   localparam int unsigned RecW     = 2 * XLEN;
   localparam int unsigned FrameW   = 8 * TRACE_FRAME_BYTES;
   localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BaudLast = 16'(CLK_DIV - 1);
   localparam logic [3:0]  ByteLast = 4'(TRACE_FRAME_BYTES - 1);

   state_t           prev_q;
   logic             capture, push, pop, drop, full, empty;
   logic [CntW-1:0]  count;
   logic [RecW-1:0]  rdata;

   // prev_q resets to FETCH so a core sitting in FETCH at reset release is not traced.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) prev_q <= FETCH;
      else         prev_q <= trc.state_i;
   end

   assign capture = trc.en_i && (trc.state_i == FETCH) && (prev_q != FETCH);
   assign push    = capture && (!full || pop);
   assign drop    = capture && !push;

   sync_fifo #(
      .WIDTH (RecW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({trc.pc_i, trc.instr_i}),
      .rdata_o (rdata),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   // Serializer. frame_q holds the remaining bytes, current byte in the top 8 bits.
   tx_state_t         state_q, state_d;
   logic [15:0]       baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [3:0]        byte_q, byte_d;
   logic [FrameW-1:0] frame_q, frame_d;
   logic [7:0]        cur_byte;
   logic              baud_done, tx;

   assign cur_byte  = frame_q[FrameW-1 -: 8];
   assign baud_done = (baud_q == BaudLast);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 16'd1;
      bit_d   = bit_q;
      byte_d  = byte_q;
      frame_d = frame_q;
      pop     = 1'b0;
      tx      = 1'b1;
      unique case (state_q)
         TX_IDLE: begin
            baud_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               frame_d = {TRACE_SYNC, rdata};
               byte_d  = '0;
               state_d = TX_START;
            end
         end
         TX_START: begin
            tx = 1'b0;
            if (baud_done) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            tx = cur_byte[bit_q];
            if (baud_done) begin
               baud_d = '0;
               if (bit_q == 3'd7) state_d = TX_STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         TX_STOP: begin
            if (baud_done) begin
               baud_d = '0;
               if (byte_q < ByteLast) begin
                  byte_d  = byte_q + 4'd1;
                  frame_d = frame_q << 8;
                  state_d = TX_START;
               end else begin
                  state_d = TX_IDLE;
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= TX_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         frame_q <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         frame_q <= frame_d;
      end
   end

   logic       overflow_q;
   logic [7:0] drop_cnt_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   // tx is decoded from the state register, so reset forces it high without a clock.
   assign trc.tx_o       = tx;
   assign trc.busy_o     = (count != '0) || (state_q != TX_IDLE);
   assign trc.overflow_o = overflow_q;
   assign trc.drop_cnt_o = drop_cnt_q;

endmodule
